// File: rtl/clk_div_seq_pkg.sv
// Shared types and helpers for the divided-clock edge sequencer.
// Optional edge logging is enabled with CLK_DIV_SEQ_EDGE_LOG_EN.
`timescale 1ns/1ps
package clk_div_seq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clk_div_seq_if.sv
// Control/status bundle of the divided-clock edge sequencer.
// Master drives run controls; slave returns the divided clock and status.
`timescale 1ns/1ps
interface clk_div_seq_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_i;
    logic             load;
    logic [CNT_W-1:0] term_cnt_i;
    logic             clk_o;
    logic             pos_stb_o;
    logic             neg_stb_o;
    logic [CNT_W-1:0] cyc_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output en, div_i, load, term_cnt_i,
        input  clk_o, pos_stb_o, neg_stb_o, cyc_o, busy_o, done_o
    );

    modport slave (
        input  en, div_i, load, term_cnt_i,
        output clk_o, pos_stb_o, neg_stb_o, cyc_o, busy_o, done_o
    );
endinterface

// File: rtl/clk_div_half_cnt.sv
// Half-period counter: toggles the divided clock every d source cycles
// and emits a one-cycle strobe registered alongside each transition.
`timescale 1ns/1ps
module clk_div_half_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] d,
    input  logic             run,
    input  logic             force_low,
    input  logic             clear,
    output logic             rise_nxt,
    output logic             clk_q,
    output logic             pos_stb,
    output logic             neg_stb
);
    logic [DIV_W-1:0] cnt;
    logic             tick;

    assign tick     = (cnt == d - DIV_W'(1));
    assign rise_nxt = tick && !clk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_q   <= 1'b0;
            pos_stb <= 1'b0;
            neg_stb <= 1'b0;
        end else begin
            pos_stb <= 1'b0;
            neg_stb <= 1'b0;
            unique case (1'b1)
                clear: begin
                    cnt   <= '0;
                    clk_q <= 1'b0;
                end
                force_low: begin
                    cnt   <= '0;
                    clk_q <= 1'b0;
                end
                run: begin
                    if (tick) begin
                        cnt     <= '0;
                        clk_q   <= !clk_q;
                        pos_stb <= !clk_q;
                        neg_stb <= clk_q;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/clk_div_sequencer.sv
// Divided-clock edge sequencer: FSM, rise counter, divisor reload, done flag.
// Define CLK_DIV_SEQ_EDGE_LOG_EN for simulation-only edge logging.
`timescale 1ns/1ps
module clk_div_sequencer
    import clk_div_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    clk_div_seq_if.slave bus
);
    state_t           state, state_n;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] term;
    logic [DIV_W-1:0] d;
    logic [DIV_W-1:0] d_new;
    logic             pend;
    logic             done;
    logic             run, force_low, clear;
    logic             rise_nxt, rise_ok, tc_hit;
    logic             clk_q, pos_stb, neg_stb;

    assign d_new = DIV_W'(eff_div(32'(bus.div_i)));

    clk_div_half_cnt #(.DIV_W(DIV_W)) u_half (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .run       (run),
        .force_low (force_low),
        .clear     (clear),
        .rise_nxt  (rise_nxt),
        .clk_q     (clk_q),
        .pos_stb   (pos_stb),
        .neg_stb   (neg_stb)
    );

    // A terminal rise wins over a coincident en drop for that cycle.
    always_comb begin
        state_n   = state;
        run       = 1'b0;
        force_low = 1'b0;
        clear     = 1'b0;
        tc_hit    = 1'b0;
        rise_ok   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.en) begin
                    state_n = S_RUN;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                tc_hit = rise_nxt && (cyc == term);
                if (tc_hit) begin
                    state_n = S_DONE;
                    run     = 1'b1;
                end else if (!bus.en) begin
                    state_n   = S_IDLE;
                    force_low = 1'b1;
                end else begin
                    run = 1'b1;
                end
                rise_ok = rise_nxt && run;
            end
            S_DONE: begin
                if (!bus.en) begin
                    state_n   = S_IDLE;
                    force_low = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cyc   <= '0;
            term  <= '0;
            d     <= DIV_W'(1);
            pend  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            if (clear) begin
                cyc  <= '0;
                term <= bus.term_cnt_i;
                d    <= d_new;
                pend <= 1'b0;
            end else if (rise_ok) begin
                cyc <= cyc + CNT_W'(1);
                if (pend || bus.load) begin
                    d <= d_new;
                end
                pend <= 1'b0;
            end else if (bus.load) begin
                pend <= 1'b1;
            end
            if (tc_hit) begin
                done <= 1'b1;
            end else if (state == S_DONE && !bus.en) begin
                done <= 1'b0;
            end
        end
    end

    assign bus.clk_o     = clk_q;
    assign bus.pos_stb_o = pos_stb;
    assign bus.neg_stb_o = neg_stb;
    assign bus.cyc_o     = cyc;
    assign bus.busy_o    = (state == S_RUN);
    assign bus.done_o    = done;

`ifdef CLK_DIV_SEQ_EDGE_LOG_EN
    always @(posedge clk) begin
        if (pos_stb) $display("[%0t] posedge; cyc == %0d", $time, cyc);
        if (neg_stb) $display("[%0t] negedge; cyc == %0d", $time, cyc);
        if (state != S_DONE && state_n == S_DONE) begin
            $display("*-* All Finished *-*");
        end
    end
`else
`endif
endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed self-checking bench for clk_div_sequencer.
// Edge n = n-th clk posedge after the one that samples en (IDLE->RUN).
`timescale 1ns/1ps
module tb_clk_div_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] pm, nm, dm;

    clk_div_seq_if #(.CNT_W(16), .DIV_W(8)) bus ();

    clk_div_sequencer #(.CNT_W(16), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            tick();
            pm[i] = bus.pos_stb_o;
            nm[i] = bus.neg_stb_o;
            dm[i] = bus.done_o;
        end
    endtask

    task automatic start(input logic [7:0] dv, input logic [15:0] tc);
        bus.div_i      = dv;
        bus.term_cnt_i = tc;
        bus.en         = 1'b1;
        pm = '0;
        nm = '0;
        dm = '0;
        tick();
    endtask

    task automatic stop();
        bus.en = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        pm = '0;
        nm = '0;
        dm = '0;
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.div_i      = 8'd1;
        bus.load       = 1'b0;
        bus.term_cnt_i = 16'd0;
        #1;
        chk("rst_clk", 32'(bus.clk_o), 32'd0);
        chk("rst_pos", 32'(bus.pos_stb_o), 32'd0);
        chk("rst_neg", 32'(bus.neg_stb_o), 32'd0);
        chk("rst_cyc", 32'(bus.cyc_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        #12;
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_clk", 32'(bus.clk_o), 32'd0);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);

        // D=1, term=10: rises on odd edges, 11th on edge 21
        start(8'd1, 16'd10);
        chk("d1_busy0", 32'(bus.busy_o), 32'd1);
        chk("d1_clk0", 32'(bus.clk_o), 32'd0);
        steps(1, 21);
        chk("d1_pos", pm, 32'h002A_AAAA);
        chk("d1_neg", nm, 32'h0015_5554);
        chk("d1_done", dm, 32'h0020_0000);
        chk("d1_cyc", 32'(bus.cyc_o), 32'd11);
        chk("d1_busy", 32'(bus.busy_o), 32'd0);
        tick();
        tick();
        chk("d1_hold_clk", 32'(bus.clk_o), 32'd1);
        chk("d1_hold_pos", 32'(bus.pos_stb_o), 32'd0);
        chk("d1_hold_cyc", 32'(bus.cyc_o), 32'd11);
        chk("d1_hold_done", 32'(bus.done_o), 32'd1);
        stop();
        chk("d1_off_clk", 32'(bus.clk_o), 32'd0);
        chk("d1_off_neg", 32'(bus.neg_stb_o), 32'd0);
        chk("d1_off_done", 32'(bus.done_o), 32'd0);

        // D=3, term=2: rises at 3,9,15; falls at 6,12
        start(8'd3, 16'd2);
        chk("d3_cyc0", 32'(bus.cyc_o), 32'd0);
        steps(1, 16);
        chk("d3_pos", pm, 32'h0000_8208);
        chk("d3_neg", nm, 32'h0000_1040);
        chk("d3_done", dm, 32'h0001_8000);
        chk("d3_cyc", 32'(bus.cyc_o), 32'd3);
        stop();

        // div_i=0 behaves as D=1, term=3
        start(8'd0, 16'd3);
        steps(1, 8);
        chk("d0_pos", pm, 32'h0000_00AA);
        chk("d0_neg", nm, 32'h0000_0054);
        chk("d0_done", dm, 32'h0000_0180);
        chk("d0_cyc", 32'(bus.cyc_o), 32'd4);
        stop();

        // D=2 with load of 4 before the second rise
        start(8'd2, 16'd100);
        steps(1, 2);
        bus.load  = 1'b1;
        bus.div_i = 8'd4;
        steps(3, 3);
        bus.load = 1'b0;
        steps(4, 14);
        chk("ld_pos", pm, 32'h0000_4044);
        chk("ld_neg", nm, 32'h0000_0410);
        chk("ld_cyc", 32'(bus.cyc_o), 32'd3);
        stop();
        chk("ld_off_clk", 32'(bus.clk_o), 32'd0);

        // en dropped where the second fall would land
        start(8'd2, 16'd100);
        steps(1, 7);
        chk("en_pos", pm, 32'h0000_0044);
        chk("en_neg", nm, 32'h0000_0010);
        bus.en = 1'b0;
        tick();
        chk("en_clk", 32'(bus.clk_o), 32'd0);
        chk("en_negstb", 32'(bus.neg_stb_o), 32'd0);
        chk("en_busy", 32'(bus.busy_o), 32'd0);
        chk("en_cyc", 32'(bus.cyc_o), 32'd2);
        chk("en_done", 32'(bus.done_o), 32'd0);

        // asynchronous reset mid-RUN, then restart
        start(8'd1, 16'd100);
        steps(1, 5);
        chk("ar_pre_clk", 32'(bus.clk_o), 32'd1);
        chk("ar_pre_cyc", 32'(bus.cyc_o), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_clk", 32'(bus.clk_o), 32'd0);
        chk("ar_pos", 32'(bus.pos_stb_o), 32'd0);
        chk("ar_cyc", 32'(bus.cyc_o), 32'd0);
        chk("ar_busy", 32'(bus.busy_o), 32'd0);
        chk("ar_done", 32'(bus.done_o), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("ar_re_busy", 32'(bus.busy_o), 32'd1);
        chk("ar_re_cyc0", 32'(bus.cyc_o), 32'd0);
        tick();
        chk("ar_re_pos", 32'(bus.pos_stb_o), 32'd1);
        chk("ar_re_cyc1", 32'(bus.cyc_o), 32'd1);
        stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_sequencer.md
Name: clk_div_sequencer

Overview:
- Synchronous edge sequencer clocked by the free-running testbench clock `clk`.
- Produces a programmable divided clock `clk_o`, plus one-cycle posedge and negedge strobes aligned with its transitions.
- Counts divided posedges and flags completion at a terminal count, replacing per-test hand-written cycle counters and finish checks.
- Downstream consumers use the strobes and `done_o` to sequence checks and end simulation.

Parameters:
- CNT_W, 16, width of the divided-posedge counter and terminal count.
- DIV_W, 8, width of the half-period divisor.

Ports:
- clk  in  1  free-running source clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request; level-sensitive.
- div_i  in  DIV_W  half-period of `clk_o` in `clk` cycles; 0 treated as 1.
- load  in  1  one-cycle pulse; requests adoption of `div_i` at the next divided posedge.
- term_cnt_i  in  CNT_W  terminal count; sampled on IDLE->RUN.
- clk_o  out  1  divided clock (registered).
- pos_stb_o  out  1  high for the `clk` cycle in which `clk_o` rises.
- neg_stb_o  out  1  high for the `clk` cycle in which `clk_o` falls.
- cyc_o  out  CNT_W  number of divided posedges since start, pre-increment value semantics.
- busy_o  out  1  high in RUN.
- done_o  out  1  sticky completion flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; half counter 0; divisor register=1; load pending cleared. All outputs drop immediately, without waiting for a clock edge, including mid-RUN.

State IDLE:
- `clk_o`=0, no strobes.
- `en`=1 sampled at a `clk` posedge -> RUN next cycle.
- Same edge: `cyc_o` cleared, `term_cnt_i` and effective divisor D=max(`div_i`,1) latched, half counter cleared.

State RUN (`busy_o`=1):
- Half counter increments every cycle.
- When counter==D-1: counter resets to 0, `clk_o` toggles, and the matching strobe is asserted in the same cycle `clk_o` takes its new value.
- The first RUN cycle with counter==D-1 produces a rise; `clk_o` period = 2*D `clk` cycles, 50% duty.
- On each rise, `cyc_o` <= `cyc_o`+1, wrapping at 2^CNT_W.
- If the pre-increment `cyc_o` equals the latched terminal count on that rise: next state DONE, `done_o` <= 1. `cyc_o` still increments.
- A `load` pulse sets a pending flag. At the next rise, D <= max(`div_i`,1) as sampled at that rise and the flag clears. The new D governs the following fall.
- `load` coincident with a rise is adopted at that rise.
- `en`=0 in RUN: IDLE next cycle. `clk_o` forced 0 with no `neg_stb_o`. `cyc_o` holds. `done_o` unchanged (stays 0).

State DONE:
- `clk_o` holds 1; no strobes; counter frozen; `done_o`=1; `busy_o`=0.
- `en`=0 -> IDLE: `clk_o`=0 with no strobe; `done_o` cleared.

Simultaneous events:
- Terminal match and `en`=0 in the same cycle: DONE wins for that cycle. The subsequent `en`=0 then returns to IDLE.
- `pos_stb_o` and `neg_stb_o` are never high together.

Terminal count 0: `done_o` asserts after the first rise.

Optional Feature:
- Macro: CLK_DIV_SEQ_EDGE_LOG_EN.
- Defined: simulation-only logging on each strobe, printing time, edge kind, and `cyc_o`, in the form "[T] posedge; cyc == N". Entering DONE prints "*-* All Finished *-*".
- Undefined: no display statements compiled. RTL behaviour is identical either way.

Decomposition:
- Package clk_div_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default width localparams;
  - a function computing effective divisor max(div,1).
- Sub-module clk_div_half_cnt: half-period counter plus toggle/strobe generation, with inputs D, run, and force_low. The top-level owns the FSM, `cyc_o`, the load-pending logic, and `done_o`.

Test Plan:
- D=1, term=10, `en` held high: `clk_o` toggles every cycle. 11 `pos_stb_o` pulses occur, the 11th at RUN cycle 20. `done_o`=1 from RUN cycle 21. `cyc_o`=11 and `clk_o` holds 1.
- D=3, term=2: `clk_o` period 6 cycles, rises at RUN cycles 2, 8, 14. Falls at cycles 5 and 11, with `neg_stb_o` there. `done_o` asserts after the cycle-14 rise.
- `div_i`=0: behaves exactly as D=1.
- D=2, `load` with `div_i`=4 at RUN cycle 2: next rise at cycle 5 adopts D=4. Following fall is 4 cycles later at cycle 9.
- `en` dropped at RUN cycle 7 with D=2, term=100: IDLE next cycle, `clk_o`=0, no `neg_stb_o`, `cyc_o`=2 held, `done_o`=0.
- `rst_n` pulsed low mid-RUN between clock edges: all outputs 0 immediately. After release with `en`=1, the sequence restarts from `cyc_o`=0.
